// File: rtl/inst_loader.sv
// ---------------------------------------------------------------------------
// inst_loader
//
// Boot/run controller placed in front of the pipelined core. A session takes
// a program of load_len words off a valid/ready stream and writes it into the
// instruction RAM starting at address 0. The core is held in reset during the
// load, then released. The controller counts run cycles until the core
// reports halt_rise, or aborts the run when an optional cycle cap is reached.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             begin a session (honoured only in IDLE or ERR)
//   load_len          program length in words, legal 1..2^PC_WIDTH
//   run_limit         run-cycle cap, 0 = unlimited
//   in_valid/in_ready/in_data   instruction word stream
//   ram_wr_en/ram_addr/ram_wr_data   instruction RAM write port
//   core_reset        reset to the core (low only while running)
//   halt_rise         one-cycle halt pulse from the core
//   busy/done/error/err_code    session status
//   cycle_cnt         run cycles of the most recent session
// ---------------------------------------------------------------------------
module inst_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int PC_WIDTH   = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [PC_WIDTH:0]     load_len,
    input  logic [CNT_WIDTH-1:0]  run_limit,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  ram_wr_en,
    output logic [PC_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  core_reset,
    input  logic                  halt_rise,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [CNT_WIDTH-1:0]  cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [PC_WIDTH:0] MAX_LEN = {1'b1, {PC_WIDTH{1'b0}}};
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    state_t                  state_reg;
    logic [PC_WIDTH:0]       words_left_reg;
    logic [PC_WIDTH-1:0]     wr_addr_reg;
    logic [CNT_WIDTH-1:0]    run_limit_reg;
    logic [CNT_WIDTH-1:0]    cycle_cnt_reg;
    logic                    ram_wr_en_reg;
    logic [PC_WIDTH-1:0]     ram_addr_reg;
    logic [DATA_WIDTH-1:0]   ram_wr_data_reg;
    logic [1:0]              err_code_reg;

    logic                    len_ok;
    logic [CNT_WIDTH-1:0]    cycle_cnt_next;

    assign len_ok = (load_len != '0) && (load_len <= MAX_LEN);

    // Saturating increment: a runaway program with no cap parks at all-ones.
    assign cycle_cnt_next = (cycle_cnt_reg == '1) ? cycle_cnt_reg
                                                  : cycle_cnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            words_left_reg  <= '0;
            wr_addr_reg     <= '0;
            run_limit_reg   <= '0;
            cycle_cnt_reg   <= '0;
            ram_wr_en_reg   <= 1'b0;
            ram_addr_reg    <= '0;
            ram_wr_data_reg <= '0;
            err_code_reg    <= ERR_NONE;
        end else begin
            // Write strobe is a single-cycle pulse per accepted word.
            ram_wr_en_reg <= 1'b0;

            case (state_reg)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        if (len_ok) begin
                            state_reg      <= S_LOAD;
                            words_left_reg <= load_len;
                            wr_addr_reg    <= '0;
                            run_limit_reg  <= run_limit;
                            cycle_cnt_reg  <= '0;
                            err_code_reg   <= ERR_NONE;
                        end else begin
                            state_reg    <= S_ERR;
                            err_code_reg <= ERR_LEN;
                        end
                    end
                end

                S_LOAD: begin
                    if (in_valid) begin
                        ram_wr_en_reg   <= 1'b1;
                        ram_addr_reg    <= wr_addr_reg;
                        ram_wr_data_reg <= in_data;
                        // Wraps to 0 after the top address on a full load.
                        wr_addr_reg     <= wr_addr_reg + 1'b1;
                        words_left_reg  <= words_left_reg - 1'b1;
                        if (words_left_reg == {{PC_WIDTH{1'b0}}, 1'b1}) begin
                            state_reg <= S_RELEASE;
                        end
                    end
                end

                // The final write is on the RAM port during this cycle, so the
                // core stays in reset one more cycle before it may fetch.
                S_RELEASE: begin
                    state_reg <= S_RUN;
                end

                S_RUN: begin
                    cycle_cnt_reg <= cycle_cnt_next;
                    if (halt_rise) begin
                        state_reg <= S_DONE;
                    end else if ((run_limit_reg != '0) &&
                                 (cycle_cnt_next == run_limit_reg)) begin
                        state_reg    <= S_ERR;
                        err_code_reg <= ERR_TIMEOUT;
                    end
                end

                S_DONE: begin
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs are pure decodes of the state register.
    assign in_ready    = (state_reg == S_LOAD);
    assign core_reset  = (state_reg != S_RUN);
    assign busy        = (state_reg == S_LOAD) || (state_reg == S_RELEASE) ||
                         (state_reg == S_RUN);
    assign done        = (state_reg == S_DONE);
    assign error       = (state_reg == S_ERR);
    assign err_code    = err_code_reg;
    assign cycle_cnt   = cycle_cnt_reg;
    assign ram_wr_en   = ram_wr_en_reg;
    assign ram_addr    = ram_addr_reg;
    assign ram_wr_data = ram_wr_data_reg;

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  load_len;
    logic [15:0] run_limit;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        ram_wr_en;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wr_data;
    logic        core_reset;
    logic        halt_rise;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] cycle_cnt;

    inst_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .load_len    (load_len),
        .run_limit   (run_limit),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .ram_wr_en   (ram_wr_en),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .core_reset  (core_reset),
        .halt_rise   (halt_rise),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        bit         is_err;
        logic [1:0] code;
        int         cnt;     // -1 = count not checked
    } ev_t;

    wr_t  wr_q[$];
    ev_t  ev_q[$];
    int   total = 0;
    int   bad   = 0;
    logic [15:0] wbuf [0:255];
    logic prev_error = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: compares RAM writes and session-end events against the queues.
    always @(negedge clk) begin
        if (ram_wr_en) begin
            total++;
            if (wr_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=0x%0h data=0x%0h", ram_addr, ram_wr_data);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                if (ram_addr !== w.addr || ram_wr_data !== w.data) begin
                    bad++;
                    $display("FAIL write: got addr=0x%0h data=0x%0h expected addr=0x%0h data=0x%0h",
                             ram_addr, ram_wr_data, w.addr, w.data);
                end else begin
                    $display("ok   write addr=0x%0h data=0x%0h", ram_addr, ram_wr_data);
                end
            end
        end
        if (done || (error && !prev_error)) begin
            total++;
            if (ev_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: done=%0b error=%0b code=%0d cnt=%0d",
                         done, error, err_code, cycle_cnt);
            end else begin
                ev_t e;
                e = ev_q.pop_front();
                if ((e.is_err ? !error || done : !done || error) ||
                    (e.is_err && err_code !== e.code) ||
                    (!e.is_err && err_code !== 2'b00) ||
                    (e.cnt >= 0 && int'(cycle_cnt) != e.cnt) ||
                    core_reset !== 1'b1 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL event: got done=%0b error=%0b code=%0d cnt=%0d core_reset=%0b expected err=%0b code=%0d cnt=%0d",
                             done, error, err_code, cycle_cnt, core_reset, e.is_err, e.code, e.cnt);
                end else begin
                    $display("ok   event done=%0b error=%0b code=%0d cnt=%0d", done, error, err_code, cycle_cnt);
                end
            end
        end
        prev_error <= error;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len, input int limit);
        start     = 1'b1;
        load_len  = len[8:0];
        run_limit = limit[15:0];
        tick(1);
        start     = 1'b0;
    endtask

    // Feed n words from wbuf; expected writes are queued as each word is taken.
    task automatic send(input int n, input bit toggle);
        int  i   = 0;
        int  cyc = 0;
        logic rdy;
        while (i < n && cyc < 2000) begin
            in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            in_data  = wbuf[i];
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy) begin
                wr_t w;
                w.addr = i[7:0];
                w.data = wbuf[i];
                wr_q.push_back(w);
                i++;
            end
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (i < n) begin
            total++;
            bad++;
            $display("FAIL load_timeout: accepted %0d of %0d", i, n);
        end
    endtask

    task automatic push_ev(input bit is_err, input logic [1:0] code, input int cnt);
        ev_t e;
        e.is_err = is_err;
        e.code   = code;
        e.cnt    = cnt;
        ev_q.push_back(e);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},   in_ready,    0);
        check({tag, "_wr_en"},      ram_wr_en,   0);
        check({tag, "_addr"},       ram_addr,    0);
        check({tag, "_wr_data"},    ram_wr_data, 0);
        check({tag, "_core_reset"}, core_reset,  1);
        check({tag, "_busy"},       busy,        0);
        check({tag, "_done"},       done,        0);
        check({tag, "_error"},      error,       0);
        check({tag, "_err_code"},   err_code,    0);
        check({tag, "_cycle_cnt"},  cycle_cnt,   0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; load_len = '0; run_limit = '0;
        in_valid = 1'b0; in_data = '0; halt_rise = 1'b0;
        wbuf[0] = 16'h1A01; wbuf[1] = 16'h2B02; wbuf[2] = 16'h3C03; wbuf[3] = 16'hA000;
        tick(3);
        reset = 1'b0;
        check_reset_vals("rst");

        // Load 4 words back-to-back, then halt on the 10th run cycle.
        do_start(4, 0);
        check("load_in_ready", in_ready, 1);
        check("load_busy", busy, 1);
        send(4, 1'b0);
        check("release_core_reset", core_reset, 1);
        check("release_in_ready", in_ready, 0);
        tick(1);
        check("run_core_reset", core_reset, 0);
        tick(9);
        halt_rise = 1'b1;
        push_ev(1'b0, 2'b00, 10);
        tick(1);
        halt_rise = 1'b0;
        tick(1);
        check("idle_after_done_busy", busy, 0);
        check("idle_after_done_cr", core_reset, 1);
        check("idle_cycle_cnt_hold", cycle_cnt, 10);

        // Toggling valid, run cap 5 with no halt -> timeout.
        do_start(4, 5);
        send(4, 1'b1);
        tick(1);
        push_ev(1'b1, 2'b10, 5);
        tick(6);
        check("timeout_error", error, 1);
        check("timeout_code", err_code, 2);
        check("timeout_cnt", cycle_cnt, 5);
        halt_rise = 1'b1;
        tick(1);
        halt_rise = 1'b0;
        check("err_ignores_halt", error, 1);

        // From ERR: cap 5 with halt on the 5th cycle -> halt wins.
        wbuf[0] = 16'h7777;
        do_start(1, 5);
        check("restart_code_clear", err_code, 0);
        send(1, 1'b0);
        tick(1);
        tick(4);
        halt_rise = 1'b1;
        push_ev(1'b0, 2'b00, 5);
        tick(1);
        halt_rise = 1'b0;
        check("halt_wins_error", error, 0);
        check("halt_wins_done", done, 1);
        tick(1);

        // Illegal lengths.
        push_ev(1'b1, 2'b01, -1);
        do_start(0, 0);
        check("len0_code", err_code, 1);
        tick(2);
        do_start(257, 0);
        check("len257_error", error, 1);
        check("len257_code", err_code, 1);
        check("len257_in_ready", in_ready, 0);
        tick(2);

        // Full 256-word load, halt on the first run cycle.
        for (int i = 0; i < 256; i++) wbuf[i] = 16'h5000 + 16'(i);
        do_start(256, 0);
        send(256, 1'b0);
        check("full_last_addr", ram_addr, 8'hFF);
        check("full_last_data", ram_wr_data, 16'h50FF);
        tick(1);
        halt_rise = 1'b1;
        push_ev(1'b0, 2'b00, 1);
        tick(1);
        halt_rise = 1'b0;
        tick(1);

        // Reset in the middle of a load, then restart from address 0.
        wbuf[0] = 16'hC001; wbuf[1] = 16'hC002;
        do_start(4, 0);
        send(2, 1'b0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_reset_vals("midrst");
        wbuf[0] = 16'hD101; wbuf[1] = 16'hD202;
        do_start(2, 0);
        send(2, 1'b0);
        tick(1);
        tick(2);
        halt_rise = 1'b1;
        push_ev(1'b0, 2'b00, 3);
        tick(1);
        halt_rise = 1'b0;
        tick(3);

        check("pending_writes", wr_q.size(), 0);
        check("pending_events", ev_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot/run controller that sits directly upstream of the pipelined core. It accepts a program as a stream of 16-bit instruction words over a valid/ready handshake and writes them into the instruction RAM write port starting at address 0. It holds the core in reset while loading, then releases it and measures run length until the core's `halt_rise` pulse. A run cap optionally aborts runaway programs.

## Interface
Parameters:
- `DATA_WIDTH`, 16, instruction word width
- `PC_WIDTH`, 8, instruction RAM address width (depth = 2^PC_WIDTH)
- `CNT_WIDTH`, 16, run-cycle counter width

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a load/run session; sampled only in IDLE or ERR
- `load_len`  in  PC_WIDTH+1  word count, sampled with `start`; legal 1..2^PC_WIDTH
- `run_limit`  in  CNT_WIDTH  max run cycles, sampled with `start`; 0 = unlimited
- `in_valid`  in  1  instruction word valid
- `in_data`  in  DATA_WIDTH  instruction word
- `in_ready`  out  1  loader accepts a word this cycle
- `ram_wr_en`  out  1  instruction RAM write strobe
- `ram_addr`  out  PC_WIDTH  instruction RAM write address
- `ram_wr_data`  out  DATA_WIDTH  instruction RAM write data
- `core_reset`  out  1  reset to the core (OR'ed with system reset externally)
- `halt_rise`  in  1  one-cycle halt pulse from the core
- `busy`  out  1  high in LOAD, RELEASE, RUN
- `done`  out  1  one-cycle pulse on successful halt
- `error`  out  1  high while in ERR
- `err_code`  out  2  01 = bad length, 10 = run timeout; 00 otherwise
- `cycle_cnt`  out  CNT_WIDTH  core run cycles of the last session

## Operation
- States: IDLE, LOAD, RELEASE, RUN, DONE, ERR. All outputs decoded from registered state/registers (no input-to-output combinational paths).
- IDLE: `core_reset`=1, `in_ready`=0. `start` with legal `load_len` → LOAD, word counter = `load_len`, write address = 0, `cycle_cnt` cleared. Illegal length (0 or > 2^PC_WIDTH) → ERR, `err_code`=01.
- LOAD: `in_ready`=1, `core_reset`=1. Each `in_valid & in_ready` edge registers the word: next cycle `ram_wr_en`=1, `ram_addr`=current address, `ram_wr_data`=word; address increments (wraps to 0 after 2^PC_WIDTH−1, reached only on a full load). Accept of final word → RELEASE. `in_valid` low stalls without penalty.
- RELEASE: exactly one cycle; last write issued; `in_ready`=0, `core_reset`=1 → RUN.
- RUN: `core_reset`=0. `cycle_cnt` increments every edge in RUN, including the edge that samples `halt_rise`; saturates at all-ones. `halt_rise` → DONE. Else, if `run_limit`≠0 and incremented count equals `run_limit` → ERR, `err_code`=10. Halt and limit on the same edge: halt wins.
- DONE: one cycle, `done`=1, `core_reset`=1 → IDLE. `cycle_cnt` holds until next accepted `start`.
- ERR: `error`=1, `core_reset`=1, code held. `start` behaves as from IDLE (clears code). `halt_rise` ignored.
- `start` ignored in LOAD/RELEASE/RUN/DONE. `halt_rise` ignored outside RUN. `in_valid` ignored when `in_ready`=0.

## Timing
- Reset values: state IDLE, `in_ready` 0, `ram_wr_en` 0, `ram_addr` 0, `ram_wr_data` 0, `core_reset` 1, `busy` 0, `done` 0, `error` 0, `err_code` 00, `cycle_cnt` 0.
- `start` sampled at edge T → `in_ready`=1 from cycle T+1.
- Word accepted at edge E → RAM write during cycle E+1 (1-cycle latency).
- Last word accepted at edge E → RELEASE in cycle E+1, RUN (`core_reset`=0) from cycle E+2.
- `halt_rise` sampled at edge H → `done`=1 and `core_reset`=1 in cycle H+1.
- Minimum session with back-to-back valid: load_len + 2 cycles before core release.
- `reset` mid-session (any state): next cycle all outputs at reset values; partially written RAM contents not cleared.

## Test plan
- Load 4 words 0x1A01,0x2B02,0x3C03,0xA000 with `in_valid` held high → writes at addr 0..3 in consecutive cycles, `core_reset` falls 2 cycles after last accept.
- Same load with `in_valid` toggling every other cycle → identical addr/data sequence, no dropped or duplicated writes.
- RUN, `halt_rise` asserted on 10th RUN cycle → `done` pulses once, `cycle_cnt`=10, `core_reset`=1, state IDLE.
- `run_limit`=5, no halt → ERR after 5 RUN cycles, `err_code`=10, `cycle_cnt`=5; `halt_rise` on 5th cycle instead → DONE, `error` stays 0.
- `start` with `load_len`=0 and with 257 → ERR, `err_code`=01, no RAM writes; full 256-word load → last write addr 0xFF.
- Assert `reset` during LOAD after 2 words → all outputs at reset values next cycle; new `start` restarts at addr 0.
